// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_ctrl_pkg
// Brief  : Shared state encoding and select constants for the L1 cache control.
// Rev    : 1.0  initial release
// ============================================================================
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    localparam logic ADDR_SEL_CPU = 1'b0;
    localparam logic ADDR_SEL_WB  = 1'b1;
    localparam logic SRC_CPU      = 1'b0;
    localparam logic SRC_PMEM     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that holds at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module : cache_control
// Brief  : Control FSM for a 2-way set-associative write-back L1 cache.
// Rev    : 1.0  initial release
// ============================================================================
module cache_control
    import cache_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             lru_out,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             load_lru,
    output logic             lru_in,
    output logic             load_data0,
    output logic             load_data1,
    output logic             data_src_sel,
    output logic             set_dirty0,
    output logic             set_dirty1,
    output logic             load_line0,
    output logic             load_line1,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic             wb_way,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    state_t r_state;
    state_t w_next;
    logic   r_victim;
    logic   r_retry;

    logic   w_req;
    logic   w_hit;
    logic   w_hway;
    logic   w_victim_wb;
    logic   w_hit_inc;
    logic   w_miss_inc;
    logic   w_fill_done;

    assign w_req       = mem_read | mem_write;
    assign w_hit       = hit0 | hit1;
    assign w_hway      = hit0 ? 1'b0 : 1'b1;
    assign w_victim_wb = lru_out ? (valid1 & dirty1) : (valid0 & dirty0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_victim <= 1'b0;
            r_retry  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_retry <= 1'b0;
                if (!w_hit) begin
                    r_victim <= lru_out;
                end
            end else if (w_fill_done) begin
                r_retry <= 1'b1;
            end
        end
    end

    // Everything is gated by rst_n so pmem requests drop the moment reset asserts.
    always_comb begin
        w_next        = r_state;
        mem_resp      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        load_data0    = 1'b0;
        load_data1    = 1'b0;
        data_src_sel  = SRC_CPU;
        set_dirty0    = 1'b0;
        set_dirty1    = 1'b0;
        load_line0    = 1'b0;
        load_line1    = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = ADDR_SEL_CPU;
        wb_way        = 1'b0;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;
        w_fill_done   = 1'b0;

        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_hit) begin
                        mem_resp  = 1'b1;
                        load_lru  = 1'b1;
                        lru_in    = w_hway;
                        w_hit_inc = ~r_retry;
                        if (mem_write) begin
                            data_src_sel = SRC_CPU;
                            load_data0   = ~w_hway;
                            load_data1   = w_hway;
                            set_dirty0   = ~w_hway;
                            set_dirty1   = w_hway;
                        end
                    end else if (w_req) begin
                        w_miss_inc = 1'b1;
                        w_next     = w_victim_wb ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = ADDR_SEL_WB;
                    wb_way        = r_victim;
                    if (pmem_resp) begin
                        w_next = S_FILL;
                    end
                end
                S_FILL: begin
                    pmem_read     = 1'b1;
                    pmem_addr_sel = ADDR_SEL_CPU;
                    if (pmem_resp) begin
                        // Line is installed here; the request completes as a hit next cycle.
                        w_fill_done  = 1'b1;
                        data_src_sel = SRC_PMEM;
                        load_line0   = ~r_victim;
                        load_line1   = r_victim;
                        load_data0   = ~r_victim;
                        load_data1   = r_victim;
                        w_next       = S_IDLE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_miss_inc),
        .count (miss_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_control
// Brief  : Directed self-checking bench for cache_control.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cache_control;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_read, mem_write, hit0, hit1, valid0, valid1, dirty0, dirty1;
    logic lru_out, pmem_resp;

    logic        mem_resp, load_lru, lru_in, load_data0, load_data1, data_src_sel;
    logic        set_dirty0, set_dirty1, load_line0, load_line1;
    logic        pmem_read, pmem_write, pmem_addr_sel, wb_way;
    logic [31:0] hit_count, miss_count;

    logic        s_mem_resp, s_load_lru, s_lru_in, s_load_data0, s_load_data1, s_data_src_sel;
    logic        s_set_dirty0, s_set_dirty1, s_load_line0, s_load_line1;
    logic        s_pmem_read, s_pmem_write, s_pmem_addr_sel, s_wb_way;
    logic [1:0]  s_hit_count, s_miss_count;

    int checks = 0;
    int errors = 0;

    // Bit order: mem_resp lru lru_in ld0 ld1 src sd0 sd1 line0 line1 prd pwr asel wbway
    logic [13:0] outs;
    assign outs = {mem_resp, load_lru, lru_in, load_data0, load_data1, data_src_sel,
                   set_dirty0, set_dirty1, load_line0, load_line1,
                   pmem_read, pmem_write, pmem_addr_sel, wb_way};

    always #5 clk = ~clk;

    cache_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru_out(lru_out), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .load_lru(load_lru), .lru_in(lru_in),
        .load_data0(load_data0), .load_data1(load_data1), .data_src_sel(data_src_sel),
        .set_dirty0(set_dirty0), .set_dirty1(set_dirty1),
        .load_line0(load_line0), .load_line1(load_line1),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .wb_way(wb_way),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru_out(lru_out), .pmem_resp(pmem_resp),
        .mem_resp(s_mem_resp), .load_lru(s_load_lru), .lru_in(s_lru_in),
        .load_data0(s_load_data0), .load_data1(s_load_data1), .data_src_sel(s_data_src_sel),
        .set_dirty0(s_set_dirty0), .set_dirty1(s_set_dirty1),
        .load_line0(s_load_line0), .load_line1(s_load_line1),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .pmem_addr_sel(s_pmem_addr_sel), .wb_way(s_wb_way),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; hit0 = 0; hit1 = 0;
        valid0 = 0; valid1 = 0; dirty0 = 0; dirty1 = 0;
        lru_out = 0; pmem_resp = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        mem_read = 1; hit1 = 1; pmem_resp = 1;
        #3;
        checks++;
        if (outs !== 14'b0) begin
            errors++; $display("FAIL reset_outs: got %b expected %b", outs, 14'b0);
        end
        checks++;
        if (hit_count !== 0 || miss_count !== 0) begin
            errors++; $display("FAIL reset_counts: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count);
        end
        clear_inputs();
        #3 rst_n = 1;
        step();
        checks++;
        if (outs !== 14'b0) begin
            errors++; $display("FAIL idle_quiet: got %b expected %b", outs, 14'b0);
        end
    endtask

    task automatic test_read_hit_way1();
        mem_read = 1; hit1 = 1;
        #1;
        checks++;
        if (outs !== 14'b11100000000000) begin
            errors++; $display("FAIL read_hit1_outs: got %b expected %b", outs, 14'b11100000000000);
        end
        step();
        clear_inputs();
        checks++;
        if (hit_count !== 1 || miss_count !== 0) begin
            errors++; $display("FAIL read_hit1_count: got hit=%0d miss=%0d expected 1/0", hit_count, miss_count);
        end
    endtask

    task automatic test_write_hit_way0();
        mem_write = 1; mem_read = 1; hit0 = 1; hit1 = 1;
        #1;
        checks++;
        if (outs !== 14'b11010010000000) begin
            errors++; $display("FAIL write_hit0_outs: got %b expected %b", outs, 14'b11010010000000);
        end
        step();
        clear_inputs();
        checks++;
        if (hit_count !== 2) begin
            errors++; $display("FAIL write_hit0_count: got %0d expected 2", hit_count);
        end
    endtask

    task automatic test_clean_miss();
        mem_read = 1; lru_out = 1; valid1 = 0; valid0 = 1; dirty0 = 1;
        #1;
        checks++;
        if (outs !== 14'b0) begin
            errors++; $display("FAIL clean_miss_idle: got %b expected %b", outs, 14'b0);
        end
        step();
        lru_out = 0;
        for (int i = 0; i < 3; i++) begin
            pmem_resp = (i == 2);
            #1;
            checks++;
            if (i < 2 && outs !== 14'b00000000001000) begin
                errors++; $display("FAIL clean_fill_wait%0d: got %b expected %b", i, outs, 14'b00000000001000);
            end else if (i == 2 && outs !== 14'b00001100011000) begin
                errors++; $display("FAIL clean_fill_resp: got %b expected %b", outs, 14'b00001100011000);
            end
            step();
        end
        pmem_resp = 0; hit1 = 1;
        #1;
        checks++;
        if (outs !== 14'b11100000000000) begin
            errors++; $display("FAIL clean_retry_hit: got %b expected %b", outs, 14'b11100000000000);
        end
        step();
        clear_inputs();
        checks++;
        if (hit_count !== 2 || miss_count !== 1) begin
            errors++; $display("FAIL clean_miss_count: got hit=%0d miss=%0d expected 2/1", hit_count, miss_count);
        end
    endtask

    task automatic test_dirty_miss();
        mem_write = 1; lru_out = 0; valid0 = 1; dirty0 = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            pmem_resp = (i == 1);
            #1;
            checks++;
            if (outs !== 14'b00000000000110) begin
                errors++; $display("FAIL dirty_wb%0d: got %b expected %b", i, outs, 14'b00000000000110);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            pmem_resp = (i == 1);
            #1;
            checks++;
            if (i == 0 && outs !== 14'b00000000001000) begin
                errors++; $display("FAIL dirty_fill_wait: got %b expected %b", outs, 14'b00000000001000);
            end else if (i == 1 && outs !== 14'b00010100101000) begin
                errors++; $display("FAIL dirty_fill_resp: got %b expected %b", outs, 14'b00010100101000);
            end
            step();
        end
        pmem_resp = 0; hit0 = 1; dirty0 = 0;
        #1;
        checks++;
        if (outs !== 14'b11010010000000) begin
            errors++; $display("FAIL dirty_retry_write: got %b expected %b", outs, 14'b11010010000000);
        end
        step();
        clear_inputs();
        checks++;
        if (hit_count !== 2 || miss_count !== 2) begin
            errors++; $display("FAIL dirty_miss_count: got hit=%0d miss=%0d expected 2/2", hit_count, miss_count);
        end
    endtask

    task automatic test_drop_request();
        mem_read = 1; lru_out = 1; valid1 = 1; dirty1 = 0;
        step();
        clear_inputs();
        pmem_resp = 1;
        #1;
        checks++;
        if (outs !== 14'b00001100011000) begin
            errors++; $display("FAIL drop_fill_resp: got %b expected %b", outs, 14'b00001100011000);
        end
        step();
        pmem_resp = 1;
        #1;
        checks++;
        if (outs !== 14'b0) begin
            errors++; $display("FAIL drop_idle_quiet: got %b expected %b", outs, 14'b0);
        end
        step();
        pmem_resp = 0; mem_read = 1; hit1 = 1;
        step();
        step();
        clear_inputs();
        checks++;
        if (hit_count !== 3 || miss_count !== 3) begin
            errors++; $display("FAIL drop_retry_count: got hit=%0d miss=%0d expected 3/3", hit_count, miss_count);
        end
    endtask

    task automatic test_reset_mid_fill();
        mem_read = 1; lru_out = 0; valid0 = 0;
        step();
        #1;
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++; $display("FAIL midfill_pmem_read: got %b expected 1", pmem_read);
        end
        pmem_resp = 1;
        rst_n = 0;
        #1;
        checks++;
        if (outs !== 14'b0 || hit_count !== 0 || miss_count !== 0) begin
            errors++; $display("FAIL midfill_reset: got outs=%b hit=%0d miss=%0d expected 0", outs, hit_count, miss_count);
        end
        clear_inputs();
        step();
        rst_n = 1;
        step();
        #1;
        checks++;
        if (outs !== 14'b0) begin
            errors++; $display("FAIL midfill_after_release: got %b expected %b", outs, 14'b0);
        end
    endtask

    task automatic test_saturation();
        mem_read = 1; hit0 = 1;
        for (int i = 0; i < 5; i++) step();
        clear_inputs();
        checks++;
        if (s_hit_count !== 2'd3) begin
            errors++; $display("FAIL sat_hit_count: got %0d expected 3", s_hit_count);
        end
        checks++;
        if (hit_count !== 5) begin
            errors++; $display("FAIL wide_hit_count: got %0d expected 5", hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit_way1();
        test_write_hit_way0();
        test_clean_miss();
        test_dirty_miss();
        test_drop_request();
        test_reset_mid_fill();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // pmem requests must never overlap.
    always @(negedge clk) begin
        if (pmem_read && pmem_write) begin
            errors++;
            $display("FAIL pmem_overlap: got read=%b write=%b expected not both", pmem_read, pmem_write);
        end
    end

endmodule
`default_nettype wire
